// File: rtl/dsp_frame_accumulator_pkg.sv
// Shared constants and types for the DSP frame accumulator: DSP result width,
// default slice latency and the output-buffer state encoding.
package dsp_frame_accumulator_pkg;

  localparam int DSP_P_W     = 48;
  localparam int DSP_LATENCY = 4;
  localparam int CNT_W       = 16;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/dsp_frame_accumulator_if.sv
// DSP result input, frame abort and valid/ready frame-sum output of the
// frame accumulator, bundled with producer (master) and accumulator (slave) views.
interface dsp_frame_accumulator_if
  import dsp_frame_accumulator_pkg::*;
#(
  parameter int ACC_W = 56
);
  logic               in_valid;
  logic [DSP_P_W-1:0] P;
  logic               clr;
  logic               out_ready;
  logic               out_valid;
  logic [ACC_W-1:0]   out_result;
  logic               out_sat;
  logic               overrun;

  modport master (
    output in_valid, P, clr, out_ready,
    input  out_valid, out_result, out_sat, overrun
  );

  modport slave (
    input  in_valid, P, clr, out_ready,
    output out_valid, out_result, out_sat, overrun
  );
endinterface

// File: rtl/dsp_valid_delay.sv
// LATENCY-deep 1-bit shift register that aligns an input-side valid strobe
// with the DSP slice's registered result.
module dsp_valid_delay
  import dsp_frame_accumulator_pkg::*;
#(
  parameter int LATENCY = DSP_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] stage;

  // NOTE: the delay stages are control state, so they are reset; a stale 1 would fake a sample.
  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage <= '0;
        else        stage <= din;
      end
    end else begin : g_chain
      // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage <= '0;
        else        stage <= {stage[LATENCY-2:0], din};
      end
    end
  endgenerate

  assign dout = stage[LATENCY-1];

endmodule

// File: rtl/dsp_frame_accumulator.sv
// Sums FRAME_LEN valid DSP results per frame with saturation and hands each
// frame sum to a one-entry valid/ready buffer, flagging dropped frames.
module dsp_frame_accumulator
  import dsp_frame_accumulator_pkg::*;
#(
  parameter int LATENCY   = DSP_LATENCY,
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 56
) (
  input logic                    clk,
  input logic                    rst_n,
  dsp_frame_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic             p_valid;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             frame_sat;
  logic [ACC_W-1:0] result_q;
  logic             result_sat_q;
  logic             overrun_q;
  buf_state_e       state_q, state_d;

  logic [ACC_W:0]   raw_sum;
  logic [ACC_W-1:0] sum;
  logic             sum_sat;
  logic             take;
  logic             frame_done;
  logic             load;
  logic             drop;

  dsp_valid_delay #(.LATENCY(LATENCY)) u_valid_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.in_valid),
    .dout (p_valid)
  );

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    raw_sum    = {1'b0, (cnt == '0) ? {ACC_W{1'b0}} : acc}
               + {{(ACC_W + 1 - DSP_P_W){1'b0}}, bus.P};
    sum_sat    = raw_sum[ACC_W] | frame_sat;
    sum        = sum_sat ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
    take       = p_valid & ~bus.clr;
    frame_done = take & (cnt == LAST_CNT);
    load       = frame_done & ((state_q == BUF_EMPTY) | bus.out_ready);
    drop       = frame_done & (state_q == BUF_FULL) & ~bus.out_ready;
  end

  // A completion loading into a FULL buffer that is being drained keeps it FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (load) state_d = BUF_FULL;
      BUF_FULL:  if (load) state_d = BUF_FULL;
                 else if (bus.out_ready) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      frame_sat <= 1'b0;
    end else if (bus.clr) begin
      acc       <= '0;
      cnt       <= '0;
      frame_sat <= 1'b0;
    end else if (p_valid) begin
      acc <= sum;
      if (frame_done) begin
        cnt       <= '0;
        frame_sat <= 1'b0;
      end else begin
        cnt       <= cnt + 1'b1;
        frame_sat <= sum_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q     <= '0;
      result_sat_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (load) begin
        result_q     <= sum;
        result_sat_q <= sum_sat;
      end
      if (bus.clr)   overrun_q <= 1'b0;
      else if (drop) overrun_q <= 1'b1;
    end
  end

  assign bus.out_valid  = (state_q == BUF_FULL);
  assign bus.out_result = result_q;
  assign bus.out_sat    = result_sat_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_dsp_frame_accumulator.sv
// Bench for dsp_frame_accumulator: two configurations driven through a DSP-slice
// model, a frame-level reference model, a vector table and directed corner cases.
module tb_dsp_frame_accumulator;
  import dsp_frame_accumulator_pkg::*;

  localparam int LAT  = DSP_LATENCY;
  localparam int FL_A = 4;
  localparam int AW_A = 56;
  localparam int FL_B = 2;
  localparam int AW_B = 48;
  localparam logic [47:0] MAX48 = 48'hFFFF_FFFF_FFFF;
  localparam int RING = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsp_frame_accumulator_if #(.ACC_W(AW_A)) bus_a ();
  dsp_frame_accumulator_if #(.ACC_W(AW_B)) bus_b ();

  dsp_frame_accumulator #(.LATENCY(LAT), .FRAME_LEN(FL_A), .ACC_W(AW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  dsp_frame_accumulator #(.LATENCY(LAT), .FRAME_LEN(FL_B), .ACC_W(AW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Stimulus per DUT (index 0 = A, 1 = B).
  logic        iv    [2];
  logic [47:0] smp   [2];
  logic        clr_v [2];
  logic        rdy   [2];

  // DSP slice model: the sample presented with in_valid emerges on P LAT cycles later.
  logic [47:0] dsp_pipe [2][LAT];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      dsp_pipe[d][0] <= smp[d];
      for (int k = 1; k < LAT; k++) dsp_pipe[d][k] <= dsp_pipe[d][k-1];
    end
  end

  assign bus_a.in_valid  = iv[0];
  assign bus_a.P         = dsp_pipe[0][LAT-1];
  assign bus_a.clr       = clr_v[0];
  assign bus_a.out_ready = rdy[0];
  assign bus_b.in_valid  = iv[1];
  assign bus_b.P         = dsp_pipe[1][LAT-1];
  assign bus_b.clr       = clr_v[1];
  assign bus_b.out_ready = rdy[1];

  logic        ov   [2];
  logic        ovr  [2];
  logic        osat [2];
  logic [63:0] ores [2];
  assign ov[0]   = bus_a.out_valid;
  assign ovr[0]  = bus_a.overrun;
  assign osat[0] = bus_a.out_sat;
  assign ores[0] = 64'(bus_a.out_result);
  assign ov[1]   = bus_b.out_valid;
  assign ovr[1]  = bus_b.overrun;
  assign osat[1] = bus_b.out_sat;
  assign ores[1] = 64'(bus_b.out_result);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  function automatic int frame_len(input int d);
    return (d == 0) ? FL_A : FL_B;
  endfunction

  function automatic logic [63:0] max_sum(input int d);
    return (d == 0) ? ((64'd1 << AW_A) - 64'd1) : ((64'd1 << AW_B) - 64'd1);
  endfunction

  // Reference model: frames are plain running totals; saturation means the
  // exact total does not fit in ACC_W bits.
  bit          due   [2][RING];
  int          m_n   [2];
  logic [63:0] m_tot [2];
  bit          m_full[2];
  logic [63:0] m_res [2];
  bit          m_sat [2];
  bit          m_ovr [2];
  int          cyc = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0; m_tot[d] = '0; m_full[d] = 0; m_res[d] = '0; m_sat[d] = 0; m_ovr[d] = 0;
      for (int k = 0; k < RING; k++) due[d][k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          check($sformatf("rst dut%0d out_valid", d), ov[d], 0);
          check($sformatf("rst dut%0d out_result", d), ores[d], 0);
          check($sformatf("rst dut%0d overrun", d), ovr[d], 0);
          m_n[d] = 0; m_tot[d] = '0; m_full[d] = 0; m_res[d] = '0; m_sat[d] = 0; m_ovr[d] = 0;
          for (int k = 0; k < RING; k++) due[d][k] = 0;
        end else begin
          bit          pv;
          bit          done;
          bit          fsat;
          logic [63:0] fsum;
          check($sformatf("mdl dut%0d out_valid cyc%0d", d, cyc), ov[d], m_full[d]);
          check($sformatf("mdl dut%0d overrun cyc%0d", d, cyc), ovr[d], m_ovr[d]);
          if (m_full[d]) begin
            check($sformatf("mdl dut%0d out_result cyc%0d", d, cyc), ores[d], m_res[d]);
            check($sformatf("mdl dut%0d out_sat cyc%0d", d, cyc), osat[d], m_sat[d]);
          end
          pv = due[d][cyc % RING];
          due[d][cyc % RING] = 0;
          if (iv[d] === 1'b1) due[d][(cyc + LAT) % RING] = 1;
          done = 0; fsum = '0; fsat = 0;
          if (clr_v[d]) begin
            m_n[d] = 0; m_tot[d] = '0; m_ovr[d] = 0;
          end else if (pv) begin
            m_tot[d] = m_tot[d] + 64'(dsp_pipe[d][LAT-1]);
            m_n[d]++;
            if (m_n[d] == frame_len(d)) begin
              done = 1;
              fsat = (m_tot[d] > max_sum(d));
              fsum = fsat ? max_sum(d) : m_tot[d];
              m_n[d] = 0; m_tot[d] = '0;
            end
          end
          if (done && (!m_full[d] || rdy[d])) begin
            m_full[d] = 1; m_res[d] = fsum; m_sat[d] = fsat;
          end else if (done) begin
            m_ovr[d] = 1;
          end else if (m_full[d] && rdy[d]) begin
            m_full[d] = 0;
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents n samples to DUT d with gap idle cycles between them; returns one
  // cycle after the last in_valid.
  task automatic send_frame(input int d, input logic [3:0][47:0] vals, input int n, input int gap);
    for (int j = 0; j < n; j++) begin
      iv[d] = 1'b1; smp[d] = vals[j];
      step();
      iv[d] = 1'b0; smp[d] = rnd48();
      if (j < n - 1) repeat (gap) begin
        step();
        smp[d] = rnd48();
      end
    end
  endtask

  // Waits for out_valid and checks latency from the last in_valid, result and sat.
  task automatic wait_out(input int d, input logic [63:0] exp_res, input bit exp_sat,
                          input bit pulse_chk, input string name);
    int lat;
    bit seen;
    lat = 1; seen = 0;
    for (int k = 0; k < 4 * LAT + 8; k++) begin
      if (ov[d]) begin seen = 1; break; end
      step();
      lat++;
    end
    check({name, " out_valid seen"}, seen, 1);
    if (seen) begin
      check({name, " latency"}, lat, LAT + 1);
      check({name, " out_result"}, ores[d], exp_res);
      check({name, " out_sat"}, osat[d], exp_sat);
      if (pulse_chk) begin
        step();
        check({name, " one-cycle out_valid"}, ov[d], 0);
      end
    end
  endtask

  typedef struct {
    int               dut;
    int               n;
    int               gap;
    logic [3:0][47:0] p;
    logic [63:0]      exp_res;
    bit               exp_sat;
  } vec_t;

  function automatic vec_t mk(input int dut, input int gap, input logic [47:0] a,
                              input logic [47:0] b, input logic [47:0] c,
                              input logic [47:0] e, input logic [63:0] r, input bit s);
    vec_t v;
    v.dut = dut; v.n = frame_len(dut); v.gap = gap;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = e;
    v.exp_res = r; v.exp_sat = s;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    vecs[0] = mk(0, 0, 48'd10, 48'd20, 48'd30, 48'd40, 64'd100, 0);
    vecs[1] = mk(0, 2, 48'd10, 48'd20, 48'd30, 48'd40, 64'd100, 0);
    vecs[2] = mk(0, 0, MAX48, MAX48, MAX48, MAX48, 64'h0003_FFFF_FFFF_FFFC, 0);
    vecs[3] = mk(1, 0, MAX48, 48'd1, 48'd0, 48'd0, 64'h0000_FFFF_FFFF_FFFF, 1);
    vecs[4] = mk(1, 0, 48'd5, 48'd6, 48'd0, 48'd0, 64'd11, 0);
    vecs[5] = mk(1, 1, 48'hFFFF_FFFF_FFFE, 48'd1, 48'd0, 48'd0, 64'h0000_FFFF_FFFF_FFFF, 0);

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; smp[d] = rnd48(); clr_v[d] = 1'b0; rdy[d] = 1'b1;
    end
    repeat (5) step();
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d out_valid", d), ov[d], 0);
      check($sformatf("reset dut%0d out_result", d), ores[d], 0);
      check($sformatf("reset dut%0d out_sat", d), osat[d], 0);
      check($sformatf("reset dut%0d overrun", d), ovr[d], 0);
    end

    // Vector table: one frame each, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      rdy[vecs[i].dut] = 1'b1;
      send_frame(vecs[i].dut, vecs[i].p, vecs[i].n, vecs[i].gap);
      wait_out(vecs[i].dut, vecs[i].exp_res, vecs[i].exp_sat, 1, $sformatf("vec%0d", i));
      repeat (2) step();
    end

    // Backpressure: second frame dropped, overrun sticky until clr.
    rdy[0] = 1'b0;
    send_frame(0, {48'd40, 48'd30, 48'd20, 48'd10}, 4, 0);
    wait_out(0, 64'd100, 0, 0, "bp frame1");
    send_frame(0, {48'd1, 48'd1, 48'd1, 48'd1}, 4, 0);
    repeat (LAT + 2) step();
    check("bp held out_valid", ov[0], 1);
    check("bp held out_result", ores[0], 64'd100);
    check("bp overrun set", ovr[0], 1);
    rdy[0] = 1'b1;
    step();
    check("bp accepted out_valid", ov[0], 0);
    check("bp overrun sticky", ovr[0], 1);
    step();
    check("bp overrun still sticky", ovr[0], 1);
    clr_v[0] = 1'b1;
    step();
    clr_v[0] = 1'b0;
    check("bp overrun cleared", ovr[0], 0);

    // Accept and completion on the same edge.
    rdy[0] = 1'b0;
    send_frame(0, {48'd40, 48'd30, 48'd20, 48'd10}, 4, 0);
    wait_out(0, 64'd100, 0, 0, "acc frame1");
    send_frame(0, {48'd1, 48'd1, 48'd1, 48'd1}, 4, 0);
    repeat (LAT - 1) step();
    check("acc still holds 100", ores[0], 64'd100);
    rdy[0] = 1'b1;
    step();
    check("acc+done out_valid", ov[0], 1);
    check("acc+done out_result", ores[0], 64'd4);
    check("acc+done overrun", ovr[0], 0);
    step();
    check("acc+done drained", ov[0], 0);

    // clr on the third p_valid of a frame.
    send_frame(0, {48'd0, 48'd7, 48'd6, 48'd5}, 3, 0);
    repeat (LAT - 1) step();
    clr_v[0] = 1'b1;
    step();
    clr_v[0] = 1'b0;
    check("clr no output", ov[0], 0);
    send_frame(0, {48'd4, 48'd3, 48'd2, 48'd1}, 4, 0);
    wait_out(0, 64'd10, 0, 1, "clr collision");

    // Randomized traffic on both DUTs against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]    = ($urandom_range(1, 0) == 1);
        smp[d]   = (d == 1 && $urandom_range(3, 0) == 0) ? (MAX48 - 48'($urandom_range(15, 0)))
                                                          : rnd48();
        clr_v[d] = ($urandom_range(49, 0) == 0);
        rdy[d]   = ($urandom_range(3, 0) != 0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; clr_v[d] = 1'b0; rdy[d] = 1'b1;
    end
    repeat (LAT + 3) step();
    clr_v[0] = 1'b1; clr_v[1] = 1'b1;
    step();
    clr_v[0] = 1'b0; clr_v[1] = 1'b0;

    // Asynchronous reset mid-stream with a full buffer, overrun and in_valid high.
    rdy[0] = 1'b0;
    send_frame(0, {48'd40, 48'd30, 48'd20, 48'd10}, 4, 0);
    wait_out(0, 64'd100, 0, 0, "pre-rst frame");
    send_frame(0, {48'd1, 48'd1, 48'd1, 48'd1}, 4, 0);
    repeat (LAT + 2) step();
    check("pre-rst overrun", ovr[0], 1);
    iv[0] = 1'b1; smp[0] = 48'd7;
    step();
    smp[0] = 48'd8;
    step();
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", ov[0], 0);
    check("async rst out_result", ores[0], 0);
    check("async rst out_sat", osat[0], 0);
    check("async rst overrun", ovr[0], 0);
    smp[0] = 48'd9;
    repeat (2) step();
    rst_n = 1'b1;
    iv[0] = 1'b0; rdy[0] = 1'b1;
    send_frame(0, {48'd5, 48'd4, 48'd3, 48'd2}, 4, 0);
    wait_out(0, 64'd14, 0, 1, "post-rst frame");

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
